// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard / forwarding controller.
// Select codes follow the din order of the datapath's 3-input operand muxes.
package hazard_pkg;

    localparam int unsigned REC_RW = 5;
    localparam int unsigned REC_TW = 2;

    localparam logic [1:0] SEL_REG   = 2'd0;
    localparam logic [1:0] SEL_M     = 2'd1;
    localparam logic [1:0] SEL_W     = 2'd2;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    typedef struct packed {
        logic [REC_RW-1:0] a3;
        logic [REC_TW-1:0] tnew;
        logic [REC_RW-1:0] rs;
        logic [REC_RW-1:0] rt;
    } stage_rec_t;

    function automatic logic [REC_TW-1:0] sat_dec(input logic [REC_TW-1:0] t);
        return (t == '0) ? '0 : t - REC_TW'(1);
    endfunction

    // A stage can supply a register only once its result actually exists.
    function automatic logic src_match(input stage_rec_t r, input logic [REC_RW-1:0] addr);
        return (r.a3 == addr) && (r.a3 != '0) && (r.tnew == '0);
    endfunction

    // Youngest producer wins: M before W.
    function automatic logic [1:0] fwd_sel(input stage_rec_t m, input stage_rec_t w,
                                           input logic [REC_RW-1:0] addr);
        if (src_match(m, addr)) begin
            return SEL_M;
        end else if (src_match(w, addr)) begin
            return SEL_W;
        end
        return SEL_REG;
    endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// Operand-mux control bundle between the pipeline datapath (master) and the
// hazard / forwarding controller (slave).
interface hazard_fwd_ctrl_if
    import hazard_pkg::*;
#(
    parameter int unsigned TW = REC_TW,
    parameter int unsigned RW = REC_RW
);

    logic [RW-1:0] d_rs;
    logic [RW-1:0] d_rt;
    logic [TW-1:0] d_tuse_rs;
    logic [TW-1:0] d_tuse_rt;
    logic [RW-1:0] d_a3;
    logic [TW-1:0] d_tnew;

    logic [1:0]    fwd_d_rs;
    logic [1:0]    fwd_d_rt;
    logic [1:0]    fwd_e_rs;
    logic [1:0]    fwd_e_rt;
    logic [1:0]    fwd_m_rt;
    logic          stall;

    modport master (
        output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_a3, d_tnew,
        input  fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, stall
    );

    modport slave (
        input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_a3, d_tnew,
        output fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, stall
    );

endinterface

// File: rtl/hazard_stage_reg.sv
// One pipeline-stage record {a3, tnew, rs, rt}; cleared by reset or bubble.
// Any tnew decrement is applied by the parent on rec_in.
module hazard_stage_reg
    import hazard_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       bubble,
    input  stage_rec_t rec_in,
    output stage_rec_t rec_out
);

    stage_rec_t rec_q;

    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            rec_q <= '0;
        end else begin
            rec_q <= rec_in;
        end
    end

    assign rec_out = rec_q;

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Stall and forwarding-select generation for the 5-stage pipeline. Tracks the
// E/M/W producers; all outputs are combinational from those records and D.
module hazard_fwd_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned TW = REC_TW,
    parameter int unsigned RW = REC_RW
) (
    input logic              clk,
    input logic              reset,
    hazard_fwd_ctrl_if.slave bus
);

    logic [RW-1:0] d_rs;
    logic [RW-1:0] d_rt;
    logic [RW-1:0] d_a3;
    logic [TW-1:0] d_tuse_rs;
    logic [TW-1:0] d_tuse_rt;
    logic [TW-1:0] d_tnew;

    assign d_rs      = bus.d_rs;
    assign d_rt      = bus.d_rt;
    assign d_a3      = bus.d_a3;
    assign d_tuse_rs = bus.d_tuse_rs;
    assign d_tuse_rt = bus.d_tuse_rt;
    assign d_tnew    = bus.d_tnew;

    stage_rec_t e_in, m_in, w_in;
    stage_rec_t e_q, m_q, w_q;
    logic       stall;

    always_comb begin
        e_in = '{a3: d_a3, tnew: d_tnew, rs: d_rs, rt: d_rt};
        m_in = '{a3: e_q.a3, tnew: sat_dec(e_q.tnew), rs: e_q.rs, rt: e_q.rt};
        w_in = '{a3: m_q.a3, tnew: sat_dec(m_q.tnew), rs: m_q.rs, rt: m_q.rt};
    end

    // On stall D is held upstream, so E takes a bubble while M and W drain.
    hazard_stage_reg u_stage_e (
        .clk     (clk),
        .reset   (reset),
        .bubble  (stall),
        .rec_in  (e_in),
        .rec_out (e_q)
    );

    hazard_stage_reg u_stage_m (
        .clk     (clk),
        .reset   (reset),
        .bubble  (1'b0),
        .rec_in  (m_in),
        .rec_out (m_q)
    );

    hazard_stage_reg u_stage_w (
        .clk     (clk),
        .reset   (reset),
        .bubble  (1'b0),
        .rec_in  (w_in),
        .rec_out (w_q)
    );

    // W's source fields are carried for symmetry but never compared.
    logic unused_w_src;
    assign unused_w_src = ^{w_q.rs, w_q.rt};

    // W results always exist by the time they reach W, so only E and M can stall.
    function automatic logic raw_stall(input stage_rec_t e, input stage_rec_t m,
                                       input logic [REC_RW-1:0] addr,
                                       input logic [REC_TW-1:0] tuse);
        return (addr != '0) &&
               (((e.a3 == addr) && (e.tnew > tuse)) ||
                ((m.a3 == addr) && (m.tnew > tuse)));
    endfunction

    always_comb begin
        stall = raw_stall(e_q, m_q, d_rs, d_tuse_rs) ||
                raw_stall(e_q, m_q, d_rt, d_tuse_rt);
    end

    assign bus.stall    = stall;
    assign bus.fwd_d_rs = fwd_sel(m_q, w_q, d_rs);
    assign bus.fwd_d_rt = fwd_sel(m_q, w_q, d_rt);
    assign bus.fwd_e_rs = fwd_sel(m_q, w_q, e_q.rs);
    assign bus.fwd_e_rt = fwd_sel(m_q, w_q, e_q.rt);
    assign bus.fwd_m_rt = src_match(w_q, m_q.rt) ? SEL_W : SEL_REG;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: hand-computed stall / select values
// for ALU, load-use, branch, priority, $0 and mid-run reset scenarios.
module tb_hazard_fwd_ctrl;
    import hazard_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    hazard_fwd_ctrl_if #(.TW(2), .RW(5)) bus ();

    hazard_fwd_ctrl #(.TW(2), .RW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic drive_d(input logic [4:0] rs, input logic [4:0] rt,
                           input logic [1:0] tuse_rs, input logic [1:0] tuse_rt,
                           input logic [4:0] a3, input logic [1:0] tnew);
        bus.d_rs      = rs;
        bus.d_rt      = rt;
        bus.d_tuse_rs = tuse_rs;
        bus.d_tuse_rt = tuse_rt;
        bus.d_a3      = a3;
        bus.d_tnew    = tnew;
        #1;
    endtask

    task automatic nop();
        drive_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, 2'd0);
    endtask

    task automatic drive_random();
        drive_d(5'($urandom), 5'($urandom), 2'($urandom), 2'($urandom),
                5'($urandom), 2'($urandom));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        nop();
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic st, input logic [1:0] d_rs,
                           input logic [1:0] d_rt, input logic [1:0] e_rs,
                           input logic [1:0] e_rt, input logic [1:0] m_rt);
        chk({tag, ".stall"},    {1'b0, bus.stall}, {1'b0, st});
        chk({tag, ".fwd_d_rs"}, bus.fwd_d_rs, d_rs);
        chk({tag, ".fwd_d_rt"}, bus.fwd_d_rt, d_rt);
        chk({tag, ".fwd_e_rs"}, bus.fwd_e_rs, e_rs);
        chk({tag, ".fwd_e_rt"}, bus.fwd_e_rt, e_rt);
        chk({tag, ".fwd_m_rt"}, bus.fwd_m_rt, m_rt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held two cycles with random D inputs
        reset = 1'b1;
        drive_random();
        tick();
        drive_random();
        chk_all("reset_hold", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        tick();
        reset = 1'b0;
        nop();
        chk_all("reset_rel", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        tick();
        chk_all("reset_rel1", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);

        // ALU -> ALU, then store data from W
        drive_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd8, 2'd1);
        chk_all("alu_w", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        tick();
        drive_d(5'd8, 5'd8, 2'd1, 2'd2, 5'd0, 2'd0);
        chk_all("alu_rd", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        tick();
        nop();
        chk_all("alu_e", 1'b0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0);
        tick();
        chk_all("alu_m", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2);
        flush();

        // Load-use: one stall cycle, then W forward into E
        drive_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd9, 2'd2);
        chk_all("lu_w", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        tick();
        drive_d(5'd9, 5'd0, 2'd1, TUSE_NONE, 5'd0, 2'd0);
        chk_all("lu_stall", 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        tick();
        chk_all("lu_bubble", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        tick();
        nop();
        chk_all("lu_fwd", 1'b0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0);
        flush();

        // Load in M against a D-stage compare: stall, then W forward into D
        drive_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd9, 2'd2);
        tick();
        nop();
        tick();
        drive_d(5'd9, 5'd0, 2'd0, TUSE_NONE, 5'd0, 2'd0);
        chk_all("ldm_stall", 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        tick();
        chk_all("ldm_fwd", 1'b0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0);
        flush();

        // Branch compare after ALU
        drive_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd5, 2'd1);
        tick();
        drive_d(5'd0, 5'd5, TUSE_NONE, 2'd0, 5'd0, 2'd0);
        chk_all("br_stall", 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        tick();
        chk_all("br_fwd", 1'b0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0);
        flush();

        // Priority: two writers of r7, M must win over W
        drive_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd7, 2'd1);
        tick();
        drive_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd7, 2'd1);
        tick();
        drive_d(5'd7, 5'd0, 2'd1, TUSE_NONE, 5'd0, 2'd0);
        chk_all("prio_d", 1'b0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0);
        tick();
        nop();
        chk_all("prio_e", 1'b0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0);
        flush();

        // Register $0 never stalls or forwards
        drive_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, 2'd2);
        chk_all("r0_w", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        tick();
        drive_d(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0);
        chk_all("r0_rd", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        tick();
        chk_all("r0_e", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        tick();
        chk_all("r0_m", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        flush();

        // Reset mid-operation wipes all producer state
        drive_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd12, 2'd0);
        tick();
        drive_d(5'd12, 5'd12, 2'd0, 2'd0, 5'd0, 2'd0);
        chk_all("mid_rd", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        tick();
        drive_d(5'd12, 5'd0, 2'd0, TUSE_NONE, 5'd0, 2'd0);
        chk_all("mid_pre", 1'b0, 2'd1, 2'd0, 2'd1, 2'd1, 2'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_all("mid_post", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Generates the 2-bit select codes consumed by the pipeline's 3-input forwarding muxes in the D, E and M stages of the 5-stage MIPS datapath.
- Generates the stall signal that freezes F/D and bubbles E.
- Internally tracks the destination register and Tnew of instructions in E, M and W.
- It is the control end of the operand-mux interface: the muxes consume `ctrl`, and this block produces it.

Parameters:
- `TW`, 2, width of the Tnew/Tuse fields, in cycles.
- `RW`, 5, register-address width.

Ports:
- `clk`  in  1  pipeline clock
- `reset`  in  1  synchronous, active-high reset
- `d_rs`  in  5  rs field of the instruction in D
- `d_rt`  in  5  rt field of the instruction in D
- `d_tuse_rs`  in  2  cycles until rs is needed, counted from D; 3 = not used
- `d_tuse_rt`  in  2  same for rt
- `d_a3`  in  5  destination register of the D instruction; 0 = none
- `d_tnew`  in  2  cycles, measured from E entry, until its result exists at the E/M output
- `fwd_d_rs`  out  2  D-stage compare-operand select for rs
- `fwd_d_rt`  out  2  D-stage compare-operand select for rt
- `fwd_e_rs`  out  2  E-stage ALU operand select for rs
- `fwd_e_rt`  out  2  E-stage ALU operand select for rt
- `fwd_m_rt`  out  2  M-stage store-data select
- `stall`  out  1  hold PC and F/D; insert bubble into D/E

Behaviour:

Select encoding (matches mux3 din order):
- 0 = register/pipeline value, no forwarding.
- 1 = forward from the M-stage result.
- 2 = forward from the W-stage write data.
- 3 is never driven.

Stage records:
- Three records: E, M and W, each holding {a3, tnew, rs, rt}.
- Updated on every `clk` rising edge.

Reset (`reset` = 1 at the clock edge):
- All records are cleared: a3 = 0, tnew = 0, rs = 0, rt = 0.
- All outputs are then 0, since they are combinational from the cleared records.
- Reset asserted mid-operation behaves identically; no partial state survives.

Advance, when `stall` = 0:
- E <= {d_a3, d_tnew, d_rs, d_rt}.
- M <= {E.a3, sat(E.tnew−1), E.rs, E.rt}.
- W <= {M.a3, sat(M.tnew−1), …}.
- sat() floors at 0.

Stall:
- E <= bubble (all fields 0); D is held externally.
- M and W advance normally.

Stall condition (combinational):
- stall = 1 when, for X in {rs, rt}, Xaddr ≠ 0 and any of:
  - E.a3 == Xaddr and E.tnew > tuse_X
  - M.a3 == Xaddr and M.tnew > tuse_X
- The W record always has tnew = 0 and never stalls.

Forward conditions:
- A source "matches" a register when a3 == reg, a3 ≠ 0 and tnew == 0.
- Priority: M beats W (youngest value wins).
- `fwd_d_X`: 1 if M matches d_X, else 2 if W matches, else 0.
- `fwd_e_X`: 1 if M matches E.X, else 2 if W matches, else 0. Uses the E record's rs/rt.
- `fwd_m_rt`: 2 if W matches M.rt, else 0. M-stage has no M source.

Boundary conditions:
- Register 0 never stalls and never forwards.
- A match with tnew > 0 does not forward; the stall covers that case.
- Stall and forward asserted together is legal. Selects then describe the current D operands, and the datapath discards them while held.
- No latency beyond the one-cycle record update; all outputs are combinational from the records and D inputs.

Decomposition:
- Shared package `hazard_pkg`:
  - SEL_REG = 2'd0, SEL_M = 2'd1, SEL_W = 2'd2.
  - TUSE_NONE = 2'd3.
  - Record struct {a3, tnew, rs, rt}.
- One sub-module, `hazard_stage_reg`:
  - Inputs: `clk`, `reset`, `bubble`, record in.
  - Output: record out, with saturating tnew decrement applied on the input side by the parent.
  - Instantiated three times.
- Comparison logic stays flat in the parent.

Test Plan:
1. Reset: hold `reset` = 1 for 2 cycles with random D inputs → all five selects 0 and stall 0 on the cycle after release.
2. ALU to ALU: cycle 0 D = {a3=8, tnew=1}; cycle 1 D = {rs=8, tuse_rs=1} → stall 0. Cycle 2, with that instruction in E → fwd_e_rs = 1. One cycle later, in M, the store-data path sees W as needed.
3. Load-use: D = {a3=9, tnew=2} then D = {rs=9, tuse_rs=1} → stall = 1 for exactly 1 cycle, E bubbled. On the following cycle fwd_e_rs = 2.
4. Branch compare after ALU: D = {a3=5, tnew=1} then D = {rt=5, tuse_rt=0} → stall 1 cycle, then fwd_d_rt = 1.
5. Priority: two consecutive writers to reg 7, both tnew = 1, then a reader of rs=7 in E → fwd_e_rs = 1 (M), not 2.
6. Register $0: writer with a3 = 0 and tnew = 2, followed by reader rs = 0 with tuse = 0 → stall 0 and all selects 0 throughout.
